// File: rtl/ifu_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches on the inst SRAM-like bus,
// buffers {pc,instr} pairs in order and squashes in-flight responses on redirect.
module ifu_prefetch_queue #(
  parameter int                 DEPTH    = 4,
  parameter int                 IDX_W    = $clog2(DEPTH),
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'hBFC00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_sram_req,
  output logic [ADDR_W-1:0] inst_sram_addr,
  input  logic              inst_sram_addr_ok,
  input  logic              inst_sram_data_ok,
  input  logic [DATA_W-1:0] inst_sram_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  input  logic              out_ready,
  output logic [IDX_W:0]    occupancy
);

  localparam logic [IDX_W:0] LP_DEPTH = (IDX_W+1)'(DEPTH);

  logic [IDX_W:0]    r_rd;
  logic [IDX_W:0]    r_fill;
  logic [IDX_W:0]    r_alloc;
  logic [IDX_W:0]    r_drop_cnt;
  logic [ADDR_W-1:0] r_prefetch_pc;
  logic [ADDR_W-1:0] r_pc_q    [DEPTH];
  logic [DATA_W-1:0] r_instr_q [DEPTH];

  logic w_full;
  logic w_hs;
  logic w_fill_en;
  logic w_pop;

  assign w_full         = (r_alloc - r_rd) == LP_DEPTH;
  assign inst_sram_req  = !reset && !w_full && !redirect_valid;
  assign inst_sram_addr = r_prefetch_pc;
  assign w_hs           = inst_sram_req && inst_sram_addr_ok;
  // A response only lands in the queue once every pre-redirect response has drained.
  assign w_fill_en      = inst_sram_data_ok && (r_drop_cnt == '0) && !redirect_valid && !reset;
  assign w_pop          = out_valid && out_ready;

  assign out_valid = (r_fill != r_rd);
  assign out_pc    = r_pc_q[r_rd[IDX_W-1:0]];
  assign out_instr = r_instr_q[r_rd[IDX_W-1:0]];
  assign occupancy = r_alloc - r_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd          <= '0;
      r_fill        <= '0;
      r_alloc       <= '0;
      r_drop_cnt    <= '0;
      r_prefetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      // Everything still outstanding (unfilled allocations plus earlier drops) gets squashed.
      r_rd          <= '0;
      r_fill        <= '0;
      r_alloc       <= '0;
      r_prefetch_pc <= redirect_pc;
      r_drop_cnt    <= r_drop_cnt + (r_alloc - r_fill)
                       - {{IDX_W{1'b0}}, inst_sram_data_ok};
    end else begin
      if (w_hs) begin
        r_alloc       <= r_alloc + 1'b1;
        r_prefetch_pc <= r_prefetch_pc + ADDR_W'(4);
      end
      if (inst_sram_data_ok) begin
        if (r_drop_cnt == '0) r_fill <= r_fill + 1'b1;
        else                  r_drop_cnt <= r_drop_cnt - 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs)      r_pc_q[r_alloc[IDX_W-1:0]]   <= r_prefetch_pc;
    if (w_fill_en) r_instr_q[r_fill[IDX_W-1:0]] <= inst_sram_rdata;
  end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed and randomised checks of the prefetch queue against an in-order bus
// model and an expected-pc stream that restarts at every redirect.
module tb_ifu_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          IDX_W    = 2;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [IDX_W:0] occupancy;

  always #5 clk = ~clk;

  ifu_prefetch_queue #(
    .DEPTH(DEPTH), .IDX_W(IDX_W), .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_pops   = 0;
  int          n_hs     = 0;
  logic [31:0] bus_q[$];
  logic [31:0] mdl_fetch_pc;
  logic [31:0] exp_pc;
  logic        resp_en;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus/decode cycle: drive the response, observe handshakes, advance the models.
  task automatic tick();
    logic        hs;
    logic [31:0] hs_addr;
    logic        dok;
    inst_sram_data_ok = resp_en && (bus_q.size() > 0);
    inst_sram_rdata   = inst_sram_data_ok ? instr_of(bus_q[0]) : 32'h0;
    dok = inst_sram_data_ok;
    #1;
    hs      = inst_sram_req && inst_sram_addr_ok;
    hs_addr = inst_sram_addr;
    if (hs) begin
      chk("fetch_addr", hs_addr, mdl_fetch_pc);
      mdl_fetch_pc = mdl_fetch_pc + 32'd4;
      n_hs++;
    end
    if (out_valid && out_ready && !redirect_valid) begin
      $display("pop pc=%h instr=%h", out_pc, out_instr);
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, instr_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_pops++;
    end
    if (redirect_valid) begin
      $display("redirect pc=%h", redirect_pc);
      mdl_fetch_pc = redirect_pc;
      exp_pc       = redirect_pc;
    end
    @(posedge clk);
    if (dok) void'(bus_q.pop_front());
    if (hs)  bus_q.push_back(hs_addr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
    resp_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(inst_sram_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    reset = 1'b0;
    bus_q.delete();
    mdl_fetch_pc = RESET_PC;
    exp_pc       = RESET_PC;
    #1;
    chk("rst_req_release", 32'(inst_sram_req), 32'd1);
    chk("rst_addr", inst_sram_addr, RESET_PC);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int h0;

    // T1: streaming, one pop per cycle from the third cycle
    do_reset();
    inst_sram_addr_ok = 1'b1; resp_en = 1'b1; out_ready = 1'b1;
    p0 = n_pops;
    repeat (10) tick();
    chk("t1_pops", 32'(n_pops - p0), 32'd8);
    chk("t1_occ", 32'(occupancy), 32'd2);

    // T2: decode stalled, issue stops at DEPTH
    do_reset();
    inst_sram_addr_ok = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
    h0 = n_hs;
    repeat (8) tick();
    chk("t2_hs", 32'(n_hs - h0), 32'd4);
    chk("t2_req_full", 32'(inst_sram_req), 32'd0);
    chk("t2_occ_full", 32'(occupancy), 32'd4);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_head_pc", out_pc, RESET_PC);
    out_ready = 1'b1;
    #1;
    chk("t2_req_during_pop", 32'(inst_sram_req), 32'd0);
    tick();
    out_ready = 1'b0;
    #1;
    chk("t2_req_after_pop", 32'(inst_sram_req), 32'd1);
    chk("t2_occ_after_pop", 32'(occupancy), 32'd3);

    // T3: redirect with 3 outstanding, none returned
    do_reset();
    inst_sram_addr_ok = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("t3_occ_pre", 32'(occupancy), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h80001000;
    tick();
    redirect_valid = 1'b0;
    chk("t3_occ_post", 32'(occupancy), 32'd0);
    resp_en = 1'b1;
    p0 = n_pops;
    repeat (4) tick();
    chk("t3_no_early_pop", 32'(n_pops - p0), 32'd0);
    chk("t3_out_valid", 32'(out_valid), 32'd1);
    chk("t3_head_pc", out_pc, 32'h80001000);
    chk("t3_head_instr", out_instr, instr_of(32'h80001000));
    tick();
    chk("t3_pops", 32'(n_pops - p0), 32'd1);

    // T4: redirect coincides with a response, 2 outstanding
    do_reset();
    inst_sram_addr_ok = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    resp_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h80002000;
    tick();
    redirect_valid = 1'b0;
    chk("t4_occ_post", 32'(occupancy), 32'd0);
    chk("t4_valid_r0", 32'(out_valid), 32'd0);
    tick();
    chk("t4_valid_r1", 32'(out_valid), 32'd0);
    tick();
    chk("t4_valid_r2", 32'(out_valid), 32'd1);
    chk("t4_head_pc", out_pc, 32'h80002000);
    tick();

    // T5: accumulated drops across three redirects (last two back to back)
    do_reset();
    inst_sram_addr_ok = 1'b1; resp_en = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80003000;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80004000;
    tick();
    redirect_pc = 32'h80005000;
    tick();
    redirect_valid = 1'b0;
    resp_en = 1'b1;
    p0 = n_pops;
    repeat (5) tick();
    chk("t5_no_early_pop", 32'(n_pops - p0), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd1);
    chk("t5_head_pc", out_pc, 32'h80005000);
    repeat (6) tick();
    chk("t5_pops", 32'(n_pops - p0), 32'd6);

    // T6: random traffic; slave back-pressure keeps bus outstanding within DEPTH
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      redirect_valid    = ($urandom_range(0, 19) == 0);
      redirect_pc       = $urandom & 32'hFFFF_FFFC;
      inst_sram_addr_ok = (bus_q.size() < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      resp_en           = ($urandom_range(0, 3) != 0);
      out_ready         = 1'($urandom_range(0, 1));
      tick();
      if (occupancy > 3'(DEPTH)) chk("t6_occ_bound", 32'(occupancy), 32'(DEPTH));
    end
    redirect_valid = 1'b0; inst_sram_addr_ok = 1'b0; resp_en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus_q.size() == 0 && !out_valid) break;
      tick();
    end
    chk("t6_drain_bus", 32'(bus_q.size()), 32'd0);
    chk("t6_drain_valid", 32'(out_valid), 32'd0);
    chk("t6_drain_occ", 32'(occupancy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
